axis_packet_gen: RTL and testbench

//  AXI-Stream master (transmitter) that generates framed packets for our AXIS datapath blocks.
//  It drives register slices and similar blocks during bring-up and in loopback tests.
//  On a start command it emits num_pkts packets of pkt_len beats, with a deterministic data

---
 rtl/axis_packet_gen_pkg.sv | 17 +
 rtl/axis_packet_gen_if.sv | 14 +
 rtl/axis_packet_gen.sv | 173 +++++++++++++++++
 tb/tb_axis_packet_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/axis_packet_gen_pkg.sv
// Shared definitions for the AXIS packet generator and its future checker.
// Default widths and FSM state encodings live here so both sides decode the same pattern.
package axis_packet_gen_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 16;
    localparam int CNT_W_DEF  = 16;
    localparam int GAP_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/axis_packet_gen_if.sv
// AXI-Stream bundle (tdata/tvalid/tready/tlast) with master and slave views.
interface axis_packet_gen_if
    import axis_packet_gen_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_packet_gen.sv
// Purpose: AXIS master emitting num_pkts framed packets of pkt_len beats, tdata = pkt_idx + beat_idx.
// Latency: beat 0 is valid one cycle after start; all outputs registered.
// Backpressure: holds tdata/tlast/tvalid while tready is low; tvalid never depends on tready.
module axis_packet_gen
    import axis_packet_gen_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int GAP_W  = GAP_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic [CNT_W-1:0] num_pkts,
    input  logic [GAP_W-1:0] gap_cycles,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pkt_count,
    axis_packet_gen_if.master m_axis
);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [LEN_W-1:0]   beat_q, beat_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0]  pkt_idx_q, pkt_idx_d;
    logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;
    logic [DATA_W-1:0]  tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic               stop_q, stop_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               xfer;
    logic               stop_any;
    logic [CNT_W-1:0]   count_inc;

    assign xfer      = tvalid_q && m_axis.tready;
    assign stop_any  = stop || stop_q;
    // Saturate so continuous runs never wrap the completed-packet count.
    assign count_inc = (pkt_count_q == '1) ? pkt_count_q : pkt_count_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        num_d       = num_q;
        gap_d       = gap_q;
        beat_d      = beat_q;
        gap_cnt_d   = gap_cnt_q;
        pkt_idx_d   = pkt_idx_q;
        pkt_count_d = pkt_count_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        stop_d      = stop_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SEND;
                    len_d       = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
                    num_d       = num_pkts;
                    gap_d       = gap_cycles;
                    pkt_count_d = '0;
                    pkt_idx_d   = '0;
                    beat_d      = '0;
                    stop_d      = stop;
                    tvalid_d    = 1'b1;
                    tdata_d     = '0;
                    tlast_d     = (pkt_len <= LEN_W'(1));
                end
            end
            ST_SEND: begin
                // A stop seen anywhere in the frame is honoured at its tlast.
                if (stop) stop_d = 1'b1;
                if (xfer) begin
                    if (tlast_q) begin
                        pkt_count_d = count_inc;
                        pkt_idx_d   = pkt_idx_q + DATA_W'(1);
                        beat_d      = '0;
                        if (stop_any || (num_q != '0 && pkt_count_q + CNT_W'(1) == num_q)) begin
                            state_d  = ST_DONE;
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                        end else if (gap_q == '0) begin
                            tdata_d = pkt_idx_q + DATA_W'(1);
                            tlast_d = (len_q == LEN_W'(1));
                        end else begin
                            state_d   = ST_GAP;
                            gap_cnt_d = gap_q - GAP_W'(1);
                            tvalid_d  = 1'b0;
                            tlast_d   = 1'b0;
                        end
                    end else begin
                        beat_d  = beat_q + LEN_W'(1);
                        tdata_d = tdata_q + DATA_W'(1);
                        tlast_d = (beat_q + LEN_W'(1) == len_q - LEN_W'(1));
                    end
                end
            end
            ST_GAP: begin
                if (stop_any) begin
                    state_d = ST_DONE;
                end else if (gap_cnt_q == '0) begin
                    state_d  = ST_SEND;
                    tvalid_d = 1'b1;
                    tdata_d  = pkt_idx_q;
                    tlast_d  = (len_q == LEN_W'(1));
                    beat_d   = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d = (state_d == ST_DONE);
        busy_d = (state_d == ST_SEND) || (state_d == ST_GAP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            num_q       <= '0;
            gap_q       <= '0;
            beat_q      <= '0;
            gap_cnt_q   <= '0;
            pkt_idx_q   <= '0;
            pkt_count_q <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            stop_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            num_q       <= num_d;
            gap_q       <= gap_d;
            beat_q      <= beat_d;
            gap_cnt_q   <= gap_cnt_d;
            pkt_idx_q   <= pkt_idx_d;
            pkt_count_q <= pkt_count_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            stop_q      <= stop_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_axis_packet_gen.sv
// Testbench for axis_packet_gen: table of runs plus random runs checked against a packet-level model.
module tb_axis_packet_gen;
    import axis_packet_gen_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stop;
    logic [15:0] pkt_len;
    logic [15:0] num_pkts;
    logic [7:0]  gap_cycles;
    logic        busy;
    logic        done;
    logic [15:0] pkt_count;

    axis_packet_gen_if #(.DATA_W(8)) axis ();

    axis_packet_gen dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .pkt_len    (pkt_len),
        .num_pkts   (num_pkts),
        .gap_cycles (gap_cycles),
        .busy       (busy),
        .done       (done),
        .pkt_count  (pkt_count),
        .m_axis     (axis)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int len;
        int num;
        int gap;
        int rmode;       // 0: tready=1, 1: toggling 1010, 2: random
        int stop_after;  // raise stop after this many transfers; -1 none, 0 with start
        int exp_beats;
        int exp_pkts;
    } vec_t;

    vec_t tbl[8];

    int dq[$];
    int lq[$];
    int gq[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cfg(input string name, input int len, input int num, input int gap,
                           input int rmode, input int stop_after,
                           input int exp_beats, input int exp_pkts);
        int leff, npk, s, nx, last_hs, done_cyc, ndone;
        int stall_err, drop_err, busy_err, gcnt, prev_d, p, b;
        bit counting, prev_v, prev_r, prev_l, fin;
        leff = (len == 0) ? 1 : len;
        nx = 0; last_hs = -10; done_cyc = -1; ndone = 0;
        stall_err = 0; drop_err = 0; busy_err = 0; gcnt = 0; prev_d = 0;
        counting = 0; prev_v = 0; prev_r = 0; prev_l = 0; fin = 0;
        dq.delete(); lq.delete(); gq.delete();

        pkt_len    = 16'(len);
        num_pkts   = 16'(num);
        gap_cycles = 8'(gap);
        stop       = (stop_after == 0);
        start      = 1'b1;
        axis.tready = 1'b1;
        tick();
        start = 1'b0;
        chk($sformatf("%s latency_tvalid", name), int'(axis.tvalid), 1);
        chk($sformatf("%s first_tdata", name), int'(axis.tdata), 0);

        for (int c = 0; c < 3000 && !fin; c++) begin
            start = 1'b0;
            if (c == 2 && busy) begin
                start   = 1'b1;   // must be ignored mid-run
                pkt_len = 16'd9;
            end
            if (stop_after > 0 && nx >= stop_after) stop = 1'b1;
            case (rmode)
                0:       axis.tready = 1'b1;
                1:       axis.tready = (c % 2 == 0);
                default: axis.tready = 1'($urandom_range(0, 1));
            endcase

            if (done) begin
                ndone++;
                done_cyc = c;
                fin = 1'b1;
            end else if (!busy) begin
                busy_err++;
            end
            if (axis.tvalid && prev_v && !prev_r &&
                (int'(axis.tdata) != prev_d || axis.tlast != prev_l)) stall_err++;
            if (!axis.tvalid && prev_v && !(prev_r && prev_l)) drop_err++;
            if (counting) begin
                if (!axis.tvalid) gcnt++;
                else begin
                    gq.push_back(gcnt);
                    counting = 1'b0;
                end
            end
            if (axis.tvalid && axis.tready) begin
                dq.push_back(int'(axis.tdata));
                lq.push_back(int'(axis.tlast));
                nx++;
                if (axis.tlast) begin
                    last_hs  = c;
                    counting = 1'b1;
                    gcnt     = 0;
                end
            end
            prev_v = axis.tvalid;
            prev_r = axis.tready;
            prev_l = axis.tlast;
            prev_d = int'(axis.tdata);
            if (!fin) tick();
        end

        stop = 1'b0;
        start = 1'b0;
        chk($sformatf("%s done_seen", name), ndone, 1);
        chk($sformatf("%s done_after_last_beat", name), done_cyc, last_hs + 1);
        chk($sformatf("%s pkt_count", name), int'(pkt_count), exp_pkts);
        tick();
        chk($sformatf("%s done_one_cycle", name), int'(done), 0);
        chk($sformatf("%s idle_busy", name), int'(busy), 0);
        chk($sformatf("%s idle_tvalid", name), int'(axis.tvalid), 0);

        // Packet-level model: npk packets of leff beats, data = pkt + beat.
        npk = num;
        if (stop_after >= 0) begin
            s = stop_after / leff + 1;
            if (num == 0 || s < num) npk = s;
        end
        chk($sformatf("%s beats", name), dq.size(), exp_beats);
        for (int i = 0; i < dq.size() && i < npk * leff; i++) begin
            p = i / leff;
            b = i % leff;
            chk($sformatf("%s tdata[%0d]", name, i), dq[i], (p + b) % 256);
            chk($sformatf("%s tlast[%0d]", name, i), lq[i], int'(b == leff - 1));
        end
        chk($sformatf("%s gap_count", name), gq.size(), npk - 1);
        foreach (gq[i]) chk($sformatf("%s gap[%0d]", name, i), gq[i], gap);
        chk($sformatf("%s stall_stable", name), stall_err, 0);
        chk($sformatf("%s tvalid_no_drop", name), drop_err, 0);
        chk($sformatf("%s busy_during_run", name), busy_err, 0);
    endtask

    initial begin
        int len, num, gap;
        tbl[0] = '{len:4, num:2, gap:0, rmode:0, stop_after:-1, exp_beats:8,  exp_pkts:2};
        tbl[1] = '{len:3, num:1, gap:0, rmode:1, stop_after:-1, exp_beats:3,  exp_pkts:1};
        tbl[2] = '{len:2, num:3, gap:5, rmode:0, stop_after:-1, exp_beats:6,  exp_pkts:3};
        tbl[3] = '{len:5, num:0, gap:0, rmode:2, stop_after:12, exp_beats:15, exp_pkts:3};
        tbl[4] = '{len:0, num:3, gap:0, rmode:0, stop_after:-1, exp_beats:3,  exp_pkts:3};
        tbl[5] = '{len:1, num:3, gap:2, rmode:1, stop_after:-1, exp_beats:3,  exp_pkts:3};
        tbl[6] = '{len:4, num:2, gap:1, rmode:0, stop_after:0,  exp_beats:4,  exp_pkts:1};
        tbl[7] = '{len:6, num:0, gap:3, rmode:2, stop_after:7,  exp_beats:12, exp_pkts:2};

        reset = 1'b1; start = 1'b0; stop = 1'b0;
        pkt_len = '0; num_pkts = '0; gap_cycles = '0;
        axis.tready = 1'b0;
        repeat (3) tick();
        chk("reset tvalid", int'(axis.tvalid), 0);
        chk("reset tlast", int'(axis.tlast), 0);
        chk("reset tdata", int'(axis.tdata), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset pkt_count", int'(pkt_count), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_cfg($sformatf("tbl%0d", i), tbl[i].len, tbl[i].num, tbl[i].gap,
                    tbl[i].rmode, tbl[i].stop_after, tbl[i].exp_beats, tbl[i].exp_pkts);
            repeat (2) tick();
        end

        // Reset mid-packet while stalled abandons the frame.
        pkt_len = 16'd4; num_pkts = 16'd1; gap_cycles = 8'd0;
        axis.tready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("midreset stalled_tvalid", int'(axis.tvalid), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset tvalid", int'(axis.tvalid), 0);
        chk("midreset pkt_count", int'(pkt_count), 0);
        chk("midreset busy", int'(busy), 0);
        chk("midreset tdata", int'(axis.tdata), 0);
        tick();
        run_cfg("post_reset", 3, 1, 0, 0, -1, 3, 1);
        repeat (2) tick();

        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(0, 6);
            num = $urandom_range(1, 4);
            gap = $urandom_range(0, 4);
            run_cfg($sformatf("rand%0d", r), len, num, gap, 2, -1,
                    ((len == 0) ? 1 : len) * num, num);
            repeat (2) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected end");
        $fatal(1);
    end

endmodule
